// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the hazard scoreboard: shadow-entry layout and stall causes.
package hazard_scoreboard_unit_pkg;

  // Shadow entry layout, LSB first: FlagWrite, MemRead, RegWrite, rd[REG_ID_W], valid.
  localparam int unsigned FlagBit = 0;
  localparam int unsigned MrdBit  = 1;
  localparam int unsigned RwBit   = 2;
  localparam int unsigned RdLsb   = 3;

  // Full entry width for a given register-ID width.
  function automatic int unsigned entry_w(int unsigned reg_id_w);
    return reg_id_w + 4;
  endfunction

  // Position of the valid bit (MSB of the entry).
  function automatic int unsigned valid_bit(int unsigned reg_id_w);
    return reg_id_w + 3;
  endfunction

  // Which performance counter a stalled cycle is charged to.
  typedef enum logic [1:0] {
    CauseNone,
    CauseMem,
    CauseLuse,
    CauseBr
  } stall_cause_e;

endpackage

// File: rtl/hazard_scoreboard_unit_shadow_pipe.sv
// Shadow pipeline of in-flight writer descriptors (index 0 = EX, last = final MEM stage).
// Shifts one slot per cycle, inserts a NOP when the ID instruction is flushed, and
// freezes completely while the data cache is busy.
module hazard_scoreboard_unit_shadow_pipe
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_ID_W = 4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   hold,
  input  logic                                   bubble,
  input  logic [entry_w(REG_ID_W)-1:0]           entry_in,
  output logic [DEPTH*entry_w(REG_ID_W)-1:0]     stages
);

  localparam int unsigned EW = entry_w(REG_ID_W);

  // An all-zero entry has valid=0, so it can never match.
  localparam logic [EW-1:0] NopEntry = '0;

  logic [EW-1:0] stage_q [DEPTH];

  // Descriptor shift register: hold on cache miss, otherwise advance with bubble insert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= NopEntry;
      end
    end else if (!hold) begin
      stage_q[0] <= bubble ? NopEntry : entry_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign stages[i*EW +: EW] = stage_q[i];
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit beside the ID stage for a pipeline with a multi-stage data memory.
// Tracks in-flight writers in a shadow pipeline and produces load-to-use, branch-operand,
// flag and cache-busy stall/flush controls, plus saturating per-cause stall counters.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_ID_W   = 4,
  parameter int unsigned MEM_STAGES = 1,
  parameter bit          MEM_FWD_EN = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ID_W-1:0] SrcReg1,
  input  logic [REG_ID_W-1:0] SrcReg2,
  input  logic [REG_ID_W-1:0] ID_rd,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                ID_FlagWrite,
  input  logic                MemWrite,
  input  logic                Branch,
  input  logic                BR,
  input  logic                update_PC,
  input  logic                ICACHE_busy,
  input  logic                DCACHE_busy,
  output logic                PC_stall,
  output logic                IF_ID_stall,
  output logic                IF_flush,
  output logic                ID_flush,
  output logic                BE_stall,
  output logic [CNT_W-1:0]    luse_stalls,
  output logic [CNT_W-1:0]    br_stalls,
  output logic [CNT_W-1:0]    mem_stalls
);

  localparam int unsigned D  = MEM_STAGES + 1;
  localparam int unsigned EW = entry_w(REG_ID_W);
  localparam int unsigned VB = valid_bit(REG_ID_W);
  // MEM->MEM forwarding of store data only works when the load's data is ready one stage later.
  localparam bit FwdOk = MEM_FWD_EN && (MEM_STAGES == 1);

  logic [EW-1:0]   entry_in;
  logic [D*EW-1:0] stages;
  logic [D-1:0]    match1;
  logic [D-1:0]    match2;
  logic [D-1:0]    luse_vec;
  logic            luse;
  logic            b_haz;
  logic            br_haz;
  logic            dhaz;
  stall_cause_e    cause;

  // Not every field of every stage feeds a hazard check (e.g. FlagWrite past EX).
  logic unused_stage_bits;
  assign unused_stage_bits = ^stages;

  assign entry_in = {1'b1, ID_rd, ID_RegWrite, ID_MemRead, ID_FlagWrite};

  hazard_scoreboard_unit_shadow_pipe #(
    .REG_ID_W (REG_ID_W),
    .DEPTH    (D)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .hold     (DCACHE_busy),
    .bubble   (ID_flush),
    .entry_in (entry_in),
    .stages   (stages)
  );

  // Per-stage register match and load-to-use detection.
  for (genvar s = 0; s < D; s++) begin : g_stage
    logic [EW-1:0]       ent;
    logic [REG_ID_W-1:0] rd;
    logic                live;

    assign ent  = stages[s*EW +: EW];
    assign rd   = ent[RdLsb +: REG_ID_W];
    // R0 is hard-wired, so a write to it never creates a dependency.
    assign live = ent[VB] & ent[RwBit] & (rd != '0);

    assign match1[s] = live & (rd == SrcReg1);
    assign match2[s] = live & (rd == SrcReg2);

    // Only loads still inside the data memory can starve a consumer.
    if (s < MEM_STAGES) begin : g_load
      logic exempt;
      if (FwdOk && (s == 0)) begin : g_fwd
        // Store data (Rt) can be forwarded MEM->MEM from the load one stage ahead.
        assign exempt = MemWrite;
      end else begin : g_nofwd
        assign exempt = 1'b0;
      end
      assign luse_vec[s] = ent[MrdBit] & (match1[s] | (match2[s] & ~exempt));
    end else begin : g_noload
      assign luse_vec[s] = 1'b0;
    end
  end

  assign luse = |luse_vec;
  // Flags are produced at the end of EX, so only the EX slot can hold an unresolved flag write.
  assign b_haz = Branch & stages[VB] & stages[FlagBit];
  // BR reads its target register in ID; WB writes through the register file so it is not checked.
  assign br_haz = Branch & BR & (b_haz | (|match1));
  assign dhaz = luse | b_haz | br_haz;

  // Priority mux: data cache miss, then data hazard, then front-end redirect / icache miss.
  always_comb begin
    PC_stall    = 1'b0;
    IF_ID_stall = 1'b0;
    IF_flush    = 1'b0;
    ID_flush    = 1'b0;
    BE_stall    = 1'b0;
    if (DCACHE_busy) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      BE_stall    = 1'b1;
    end else if (dhaz) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_flush    = 1'b1;
    end else begin
      // A redirect wins over an icache miss: the PC loads the target and the cache aborts.
      IF_flush = update_PC | ICACHE_busy;
      PC_stall = ICACHE_busy & ~update_PC;
    end
  end

  // Charge each stalled cycle to exactly one cause, in priority order.
  always_comb begin
    cause = CauseNone;
    if (DCACHE_busy) begin
      cause = CauseMem;
    end else if (luse) begin
      cause = CauseLuse;
    end else if (b_haz | br_haz) begin
      cause = CauseBr;
    end
  end

  // Saturating stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      luse_stalls <= '0;
      br_stalls   <= '0;
      mem_stalls  <= '0;
    end else begin
      case (cause)
        CauseMem: begin
          if (mem_stalls != '1) mem_stalls <= mem_stalls + CNT_W'(1);
        end
        CauseLuse: begin
          if (luse_stalls != '1) luse_stalls <= luse_stalls + CNT_W'(1);
        end
        CauseBr: begin
          if (br_stalls != '1) br_stalls <= br_stalls + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
